sound_scheduler: RTL and testbench
==================================

Name: sound_scheduler

Overview:
Event arbiter and sequencer that sits in front of sound_generator. Edge-detects game events: bad collision, good collision, direction change, and the sound button. It queues one pending request per source and grants them to the single tone datapath by fixed priority. It drives tone select, tone period and a play strobe for a fixed duration, separated by a silent gap. The button toggles a global mute.

Parameters:
TONE_LEN, 5000, cycles play_o stays high per granted tone (>=1)
GAP_LEN, 50, silent cycles after each tone before next grant (>=0; 0 = no gap state)
BAD_PERIOD, 16'd400, period_o value for bad-collision tone
GOOD_PERIOD, 16'd200, period_o value for good-collision tone
DIR_PERIOD, 16'd100, period_o value for direction tone

Ports:
clk  in  1  system clock
rst  in  1  synchronous reset, active-high (sampled on rising clk)
button_i  in  1  sound on/off button, level
goodColl_i  in  1  good collision, level
badColl_i  in  1  bad collision, level
direction_i  in  4  one-hot direction, 0 = no input
play_o  out  1  tone active
tone_sel_o  out  2  0 none, 1 direction, 2 good, 3 bad
period_o  out  16  divider period for current tone, 0 when idle
mute_o  out  1  1 = sound OFF
pending_o  out  3  {bad, good, dir} pending request bits
busy_o  out  1  FSM not in IDLE

Behaviour:
- Reset, synchronous, active-high: all outputs 0, mute_o=0 (sound ON), FSM=IDLE, counters 0, edge-detect history registers 0. rst asserted mid-tone → outputs reach reset values at that edge.
- Edge detect uses registered previous input values.
  - Events: rising edge of badColl_i, goodColl_i or button_i.
  - Direction event: direction_i != prev_direction and direction_i != 0.
  - Holding an input high produces only one event.
- Pending: on an event while unmuted, the pending bit sets at the same edge the input is first sampled high (edge k). Bits are cleared only by grant, mute or reset. An event on the same edge as its source's grant leaves the bit set, so it is a new request.
- FSM states: IDLE, PLAY, GAP.
  - IDLE: if any pending bit set (at edge k+1), grant the highest priority (bad > good > dir) and go to PLAY. Clear that bit, load tone_sel_o/period_o and set counter=TONE_LEN-1. play_o is therefore high starting after edge k+1 (1-cycle latency from pending).
  - PLAY: counter decrements each cycle. At 0 go to GAP (counter=GAP_LEN-1), or to IDLE if GAP_LEN=0. play_o drops, tone_sel_o=0, period_o=0 on that transition.
  - GAP: silent. At count 0 go to IDLE; a pending request is granted at the following edge.
- Preemption: in PLAY with tone_sel_o != 3 and bad pending → next edge restarts PLAY with bad tone. Counter reloads TONE_LEN-1 and the bad bit clears. The preempted tone is discarded, not requeued. Bad arriving during a bad tone or a GAP waits normally.
- Simultaneous events on one edge: all bits set; grants follow strictly by priority, one tone + gap each.
- Mute: a button event toggles mute_o at that edge.
  - Entering mute: FSM→IDLE, pending cleared, play_o/tone_sel_o/period_o zero at that edge.
  - While muted: events are not latched, but edge history still updates.
  - Unmute does not replay anything.
- Button event coinciding with other events when entering mute: mute wins and nothing is latched.
- busy_o = (state != IDLE). pending_o is a direct view of the pending register.
- Counter width is $clog2(max(TONE_LEN,GAP_LEN)+1); no wrap is possible.

Test Plan:
(use TONE_LEN=8, GAP_LEN=2)
- Reset: rst=1 for 3 cycles → play_o=0, tone_sel_o=0, period_o=0, mute_o=0, pending_o=0; still 0 one cycle after release.
- Single good pulse: goodColl_i high 5 cycles → pending_o=3'b010 for 1 cycle. Then play_o=1, tone_sel_o=2, period_o=200 for exactly 8 cycles, 2 silent cycles, and exactly one tone despite 5-cycle hold.
- Simultaneous bad+good+direction=4'b0001 on one edge → tones in order 3,2,1, each 8 cycles high with a 2-cycle gap; busy_o high for 30 cycles.
- Preemption: direction=4'b0010 starts a tone; badColl_i rises at play cycle 3 → tone_sel_o switches to 3 on the next edge and lasts a full 8 cycles; the direction tone is never resumed.
- Mute: button_i pulse during a good tone → same edge mute_o=1, play_o=0, pending_o=0. goodColl_i pulse while muted → no tone. A second button pulse → mute_o=0 with no tone played.
- Direction hold/change: direction_i 4'b0001 held 20 cycles → one tone. Change to 4'b0000 → no event. Change to 4'b1000 → one new tone.

Source files
------------

// File: rtl/sound_scheduler.sv
// Event arbiter/sequencer in front of sound_generator: edge-detects game events,
// queues one request per source and plays them one at a time by fixed priority.
module sound_scheduler #(
  parameter int          TONE_LEN    = 5000,
  parameter int          GAP_LEN     = 50,
  parameter logic [15:0] BAD_PERIOD  = 16'd400,
  parameter logic [15:0] GOOD_PERIOD = 16'd200,
  parameter logic [15:0] DIR_PERIOD  = 16'd100
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        button_i,
  input  logic        goodColl_i,
  input  logic        badColl_i,
  input  logic [3:0]  direction_i,
  output logic        play_o,
  output logic [1:0]  tone_sel_o,
  output logic [15:0] period_o,
  output logic        mute_o,
  output logic [2:0]  pending_o,
  output logic        busy_o
);

  localparam int CNT_MAX = (TONE_LEN > GAP_LEN) ? TONE_LEN : GAP_LEN;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] TONE_LOAD = CW'(TONE_LEN - 1);
  localparam logic [CW-1:0] GAP_LOAD  = CW'((GAP_LEN > 0) ? (GAP_LEN - 1) : 0);
  localparam logic [CW-1:0] CNT_ZERO  = CW'(0);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PLAY = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t        state_r, state_nxt_s;
  logic [CW-1:0] cnt_r, cnt_nxt_s;
  logic          play_r, play_nxt_s;
  logic [1:0]    sel_r, sel_nxt_s;
  logic [15:0]   period_r, period_nxt_s;
  logic          mute_r, mute_nxt_s;
  logic [2:0]    pending_r, pending_nxt_s;
  logic          busy_r;
  logic          btn_prev_r, good_prev_r, bad_prev_r;
  logic [3:0]    dir_prev_r;

  logic          btn_ev_s, good_ev_s, bad_ev_s, dir_ev_s;
  logic [2:0]    ev_vec_s;
  logic          mute_enter_s, latch_en_s;
  logic [1:0]    grant_sel_s;
  logic [2:0]    clr_s;

  // Tone code 3 = bad, 2 = good, 1 = direction; bad > good > dir.
  function automatic logic [1:0] pick_tone(input logic [2:0] pend);
    logic [1:0] sel;
    if (pend[2]) begin
      sel = 2'd3;
    end else if (pend[1]) begin
      sel = 2'd2;
    end else if (pend[0]) begin
      sel = 2'd1;
    end else begin
      sel = 2'd0;
    end
    return sel;
  endfunction

  function automatic logic [15:0] tone_period(input logic [1:0] sel);
    logic [15:0] p;
    case (sel)
      2'd1:    p = DIR_PERIOD;
      2'd2:    p = GOOD_PERIOD;
      2'd3:    p = BAD_PERIOD;
      default: p = 16'd0;
    endcase
    return p;
  endfunction

  function automatic logic [2:0] tone_mask(input logic [1:0] sel);
    logic [2:0] m;
    case (sel)
      2'd1:    m = 3'b001;
      2'd2:    m = 3'b010;
      2'd3:    m = 3'b100;
      default: m = 3'b000;
    endcase
    return m;
  endfunction

  assign btn_ev_s     = button_i & ~btn_prev_r;
  assign good_ev_s    = goodColl_i & ~good_prev_r;
  assign bad_ev_s     = badColl_i & ~bad_prev_r;
  assign dir_ev_s     = (direction_i != dir_prev_r) && (direction_i != 4'd0);
  assign ev_vec_s     = {bad_ev_s, good_ev_s, dir_ev_s};
  assign mute_enter_s = btn_ev_s & ~mute_r;
  // A button edge while unmuted wins over any coincident event.
  assign latch_en_s   = ~mute_r & ~btn_ev_s;
  assign grant_sel_s  = pick_tone(pending_r);

  // Next-state, counter, tone outputs and pending-queue update.
  always_comb begin
    state_nxt_s  = state_r;
    cnt_nxt_s    = cnt_r;
    play_nxt_s   = play_r;
    sel_nxt_s    = sel_r;
    period_nxt_s = period_r;
    clr_s        = 3'b000;
    mute_nxt_s   = mute_r ^ btn_ev_s;

    case (state_r)
      ST_IDLE: begin
        if (grant_sel_s != 2'd0) begin
          state_nxt_s  = ST_PLAY;
          cnt_nxt_s    = TONE_LOAD;
          play_nxt_s   = 1'b1;
          sel_nxt_s    = grant_sel_s;
          period_nxt_s = tone_period(grant_sel_s);
          clr_s        = tone_mask(grant_sel_s);
        end else begin
          state_nxt_s  = ST_IDLE;
        end
      end
      ST_PLAY: begin
        if (pending_r[2] && (sel_r != 2'd3)) begin
          // Bad preempts a lower tone; the interrupted tone is dropped.
          cnt_nxt_s    = TONE_LOAD;
          sel_nxt_s    = 2'd3;
          period_nxt_s = BAD_PERIOD;
          clr_s        = 3'b100;
        end else if (cnt_r == CNT_ZERO) begin
          play_nxt_s   = 1'b0;
          sel_nxt_s    = 2'd0;
          period_nxt_s = 16'd0;
          if (GAP_LEN == 0) begin
            state_nxt_s = ST_IDLE;
            cnt_nxt_s   = CNT_ZERO;
          end else begin
            state_nxt_s = ST_GAP;
            cnt_nxt_s   = GAP_LOAD;
          end
        end else begin
          cnt_nxt_s    = cnt_r - CNT_ONE;
        end
      end
      ST_GAP: begin
        if (cnt_r == CNT_ZERO) begin
          state_nxt_s = ST_IDLE;
        end else begin
          cnt_nxt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        state_nxt_s  = ST_IDLE;
        cnt_nxt_s    = CNT_ZERO;
        play_nxt_s   = 1'b0;
        sel_nxt_s    = 2'd0;
        period_nxt_s = 16'd0;
      end
    endcase

    if (mute_enter_s) begin
      state_nxt_s   = ST_IDLE;
      cnt_nxt_s     = CNT_ZERO;
      play_nxt_s    = 1'b0;
      sel_nxt_s     = 2'd0;
      period_nxt_s  = 16'd0;
      pending_nxt_s = 3'b000;
    end else begin
      pending_nxt_s = (pending_r & ~clr_s) | (latch_en_s ? ev_vec_s : 3'b000);
    end
  end

  // State, counter, outputs and edge-detect history registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= ST_IDLE;
      cnt_r       <= CNT_ZERO;
      play_r      <= 1'b0;
      sel_r       <= 2'd0;
      period_r    <= 16'd0;
      mute_r      <= 1'b0;
      pending_r   <= 3'b000;
      busy_r      <= 1'b0;
      btn_prev_r  <= 1'b0;
      good_prev_r <= 1'b0;
      bad_prev_r  <= 1'b0;
      dir_prev_r  <= 4'd0;
    end else begin
      state_r     <= state_nxt_s;
      cnt_r       <= cnt_nxt_s;
      play_r      <= play_nxt_s;
      sel_r       <= sel_nxt_s;
      period_r    <= period_nxt_s;
      mute_r      <= mute_nxt_s;
      pending_r   <= pending_nxt_s;
      busy_r      <= (state_nxt_s != ST_IDLE);
      btn_prev_r  <= button_i;
      good_prev_r <= goodColl_i;
      bad_prev_r  <= badColl_i;
      dir_prev_r  <= direction_i;
    end
  end

  assign play_o     = play_r;
  assign tone_sel_o = sel_r;
  assign period_o   = period_r;
  assign mute_o     = mute_r;
  assign pending_o  = pending_r;
  assign busy_o     = busy_r;

endmodule

// File: tb/tb_sound_scheduler.sv
// Bench for sound_scheduler: directed scenarios plus random traffic, every cycle
// compared against a timeline model (tone/gap remaining-cycle bookkeeping).
module tb_sound_scheduler;

  localparam int TL = 8;
  localparam int GL = 2;

  logic        tb_clk = 1'b0;
  logic        rst, button_i, goodColl_i, badColl_i;
  logic [3:0]  direction_i;
  logic        play_o, mute_o, busy_o;
  logic [1:0]  tone_sel_o;
  logic [15:0] period_o;
  logic [2:0]  pending_o;

  always #5 tb_clk = ~tb_clk;

  sound_scheduler #(
    .TONE_LEN(TL), .GAP_LEN(GL),
    .BAD_PERIOD(16'd400), .GOOD_PERIOD(16'd200), .DIR_PERIOD(16'd100)
  ) dut (
    .clk(tb_clk), .rst(rst), .button_i(button_i), .goodColl_i(goodColl_i),
    .badColl_i(badColl_i), .direction_i(direction_i), .play_o(play_o),
    .tone_sel_o(tone_sel_o), .period_o(period_o), .mute_o(mute_o),
    .pending_o(pending_o), .busy_o(busy_o)
  );

  // Reference model: which tone sounds, how many cycles of it / of gap remain.
  bit         m_prev_btn, m_prev_good, m_prev_bad;
  logic [3:0] m_prev_dir;
  bit         m_mute;
  bit         m_pend [3];
  int         m_tone, m_play_left, m_gap_left;

  int n_chk, n_pass;
  int play_cnt, busy_cnt, pend_good_cnt;
  int tones [$];
  logic [1:0] last_sel;

  task automatic model_reset();
    m_mute = 1'b0;
    for (int i = 0; i < 3; i++) m_pend[i] = 1'b0;
    m_tone = 0; m_play_left = 0; m_gap_left = 0;
  endtask

  task automatic model_step();
    bit ev [3];
    bit b_ev, granted;
    if (rst) begin
      model_reset();
    end else begin
      b_ev  = button_i && !m_prev_btn;
      ev[2] = badColl_i && !m_prev_bad;
      ev[1] = goodColl_i && !m_prev_good;
      ev[0] = (direction_i != m_prev_dir) && (direction_i != 4'd0);
      if (b_ev && !m_mute) begin
        model_reset();
        m_mute = 1'b1;
      end else begin
        if (m_tone != 0) begin
          if (m_pend[2] && m_tone != 3) begin
            m_tone = 3; m_play_left = TL; m_pend[2] = 1'b0;
          end else begin
            m_play_left--;
            if (m_play_left == 0) begin
              m_tone = 0; m_gap_left = GL;
            end
          end
        end else if (m_gap_left > 0) begin
          m_gap_left--;
        end else begin
          granted = 1'b0;
          for (int i = 2; i >= 0; i--) begin
            if (m_pend[i] && !granted) begin
              granted = 1'b1; m_tone = i + 1; m_play_left = TL; m_pend[i] = 1'b0;
            end
          end
        end
        if (!m_mute && !b_ev)
          for (int i = 0; i < 3; i++) m_pend[i] = m_pend[i] | ev[i];
        if (b_ev) m_mute = 1'b0;
      end
    end
    m_prev_btn  = rst ? 1'b0 : button_i;
    m_prev_good = rst ? 1'b0 : goodColl_i;
    m_prev_bad  = rst ? 1'b0 : badColl_i;
    m_prev_dir  = rst ? 4'd0 : direction_i;
  endtask

  function automatic int exp_period(int t);
    case (t)
      1: return 100;
      2: return 200;
      3: return 400;
      default: return 0;
    endcase
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic clear_stats();
    play_cnt = 0; busy_cnt = 0; pend_good_cnt = 0;
    tones.delete();
  endtask

  // One clock: model advances on the edge, DUT sampled 1 time unit later.
  task automatic tick();
    @(posedge tb_clk);
    model_step();
    #1;
    check("play",     32'(play_o),     32'(m_tone != 0));
    check("tone_sel", 32'(tone_sel_o), 32'(m_tone));
    check("period",   32'(period_o),   32'(exp_period(m_tone)));
    check("mute",     32'(mute_o),     32'(m_mute));
    check("pending",  32'(pending_o),  32'({m_pend[2], m_pend[1], m_pend[0]}));
    check("busy",     32'(busy_o),     32'((m_tone != 0) || (m_gap_left > 0)));
    play_cnt += int'(play_o);
    busy_cnt += int'(busy_o);
    if (pending_o == 3'b010) pend_good_cnt++;
    if (tone_sel_o != 2'd0 && tone_sel_o != last_sel) tones.push_back(int'(tone_sel_o));
    last_sel = tone_sel_o;
  endtask

  task automatic check_idle_outputs(string tag, logic exp_mute);
    check({tag, "_play"},    32'(play_o),     32'd0);
    check({tag, "_sel"},     32'(tone_sel_o), 32'd0);
    check({tag, "_period"},  32'(period_o),   32'd0);
    check({tag, "_mute"},    32'(mute_o),     32'(exp_mute));
    check({tag, "_pending"}, 32'(pending_o),  32'd0);
  endtask

  initial begin
    int r;
    n_chk = 0; n_pass = 0; last_sel = 2'd0;
    m_prev_btn = 1'b0; m_prev_good = 1'b0; m_prev_bad = 1'b0; m_prev_dir = 4'd0;
    model_reset();
    clear_stats();
    rst = 1'b1; button_i = 1'b0; goodColl_i = 1'b0; badColl_i = 1'b0; direction_i = 4'd0;

    // Reset held three cycles, then released
    repeat (3) tick();
    check_idle_outputs("reset", 1'b0);
    rst = 1'b0;
    tick();
    check_idle_outputs("post_reset", 1'b0);

    // Single good collision held for five cycles
    clear_stats();
    goodColl_i = 1'b1;
    repeat (5) tick();
    goodColl_i = 1'b0;
    repeat (14) tick();
    check("good_play_cycles", 32'(play_cnt), 32'd8);
    check("good_busy_cycles", 32'(busy_cnt), 32'd10);
    check("good_pending_cycles", 32'(pend_good_cnt), 32'd1);
    check("good_tone_count", 32'(tones.size()), 32'd1);
    if (tones.size() > 0) check("good_tone_sel", 32'(tones[0]), 32'd2);

    // Bad, good and direction on the same edge
    clear_stats();
    badColl_i = 1'b1; goodColl_i = 1'b1; direction_i = 4'b0001;
    tick();
    badColl_i = 1'b0; goodColl_i = 1'b0; direction_i = 4'b0000;
    repeat (40) tick();
    check("simul_busy_cycles", 32'(busy_cnt), 32'd30);
    check("simul_play_cycles", 32'(play_cnt), 32'd24);
    check("simul_tone_count", 32'(tones.size()), 32'd3);
    if (tones.size() == 3) begin
      check("simul_order0", 32'(tones[0]), 32'd3);
      check("simul_order1", 32'(tones[1]), 32'd2);
      check("simul_order2", 32'(tones[2]), 32'd1);
    end

    // Bad preempts a direction tone in its third play cycle
    clear_stats();
    direction_i = 4'b0010;
    repeat (3) tick();
    badColl_i = 1'b1;
    tick();
    badColl_i = 1'b0;
    repeat (20) tick();
    direction_i = 4'b0000;
    tick();
    check("preempt_play_cycles", 32'(play_cnt), 32'd11);
    check("preempt_tone_count", 32'(tones.size()), 32'd2);
    if (tones.size() == 2) begin
      check("preempt_first", 32'(tones[0]), 32'd1);
      check("preempt_second", 32'(tones[1]), 32'd3);
    end

    // Mute during a good tone, event while muted, then unmute
    goodColl_i = 1'b1;
    tick();
    goodColl_i = 1'b0;
    repeat (3) tick();
    check("mute_pre_play", 32'(play_o), 32'd1);
    button_i = 1'b1;
    tick();
    check_idle_outputs("mute_enter", 1'b1);
    button_i = 1'b0;
    clear_stats();
    repeat (2) tick();
    goodColl_i = 1'b1;
    tick();
    goodColl_i = 1'b0;
    repeat (12) tick();
    check("muted_play_cycles", 32'(play_cnt), 32'd0);
    button_i = 1'b1;
    tick();
    button_i = 1'b0;
    repeat (12) tick();
    check("unmute_mute", 32'(mute_o), 32'd0);
    check("unmute_play_cycles", 32'(play_cnt), 32'd0);

    // Direction held, released to zero, then changed
    clear_stats();
    direction_i = 4'b0001;
    repeat (20) tick();
    check("dir_hold_tones", 32'(tones.size()), 32'd1);
    clear_stats();
    direction_i = 4'b0000;
    repeat (15) tick();
    check("dir_zero_tones", 32'(tones.size()), 32'd0);
    clear_stats();
    direction_i = 4'b1000;
    repeat (15) tick();
    check("dir_change_tones", 32'(tones.size()), 32'd1);
    check("dir_change_cycles", 32'(play_cnt), 32'd8);

    // Reset asserted mid-tone
    goodColl_i = 1'b1;
    tick();
    goodColl_i = 1'b0;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    check_idle_outputs("mid_reset", 1'b0);
    check("mid_reset_busy", 32'(busy_o), 32'd0);
    rst = 1'b0;
    tick();

    // Random traffic against the model
    for (int c = 0; c < 1500; c++) begin
      if ($urandom_range(0, 9) == 0) badColl_i = ~badColl_i;
      if ($urandom_range(0, 7) == 0) goodColl_i = ~goodColl_i;
      if ($urandom_range(0, 11) == 0) begin
        r = int'($urandom_range(0, 4));
        direction_i = (r == 0) ? 4'd0 : (4'b0001 << (r - 1));
      end
      if ($urandom_range(0, 39) == 0) button_i = ~button_i;
      rst = ($urandom_range(0, 299) == 0);
      tick();
    end
    rst = 1'b0;

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
